bin_to_bcd_seq: RTL

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq.sv | 105 ++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one shift per cycle, result W cycles after accept.
// Optional two's-complement input handling is enabled by defining BIN_TO_BCD_SIGN_EN (adds sign_out).
module bin_to_bcd_seq #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   bin_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*D-1:0] bcd_out,
  output logic           overflow
`ifdef BIN_TO_BCD_SIGN_EN
  ,
  output logic           sign_out
`endif
);

  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   opnd;
  logic [W-1:0]   mag;
  logic [4*D-1:0] acc;
  logic [4*D-1:0] adj;
  logic [4*D-1:0] shifted;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

`ifdef BIN_TO_BCD_SIGN_EN
  // -2^(W-1) negates to itself, which read unsigned is the correct magnitude.
  assign mag = bin_in[W-1] ? ((~bin_in) + W'(1)) : bin_in;
`else
  assign mag = bin_in;
`endif

  always_comb begin
    adj = acc;
    for (int i = 0; i < D; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
  end

  // The bit leaving the top digit is the decimal carry past 10^D.
  assign shifted = {adj[4*D-2:0], opnd[W-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      opnd     <= '0;
      acc      <= '0;
      bcd_out  <= '0;
      overflow <= 1'b0;
`ifdef BIN_TO_BCD_SIGN_EN
      sign_out <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opnd     <= mag;
            acc      <= '0;
            overflow <= 1'b0;
            cnt      <= CW'(W);
            state    <= CONV;
`ifdef BIN_TO_BCD_SIGN_EN
            sign_out <= bin_in[W-1];
`endif
          end
        end
        CONV: begin
          acc  <= shifted;
          opnd <= {opnd[W-2:0], 1'b0};
          cnt  <= cnt - CW'(1);
          if (adj[4*D-1]) begin
            overflow <= 1'b1;
          end
          if (cnt == CW'(1)) begin
            bcd_out <= shifted;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
